// File: rtl/reaction_control.sv
`default_nettype none
// ============================================================================
// Module   : reaction_control
// Function : Debounces the player button and sequences the reaction test
//            (idle, random wait, go, score load, result, false start).
// Revision : 1.0 - initial release
// ============================================================================
module reaction_control #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int MAX_MEASURE_CYCLES = 204700
) (
    input  logic       clk,
    input  logic       iResetn,
    input  logic       iGo,
    input  logic       iCountComplete,
    output logic       oStart_down_count,
    output logic       oStart_up_count,
    output logic       oLoad_score,
    output logic [1:0] oScreen,
    output logic       oFalseStart,
    output logic       oTimedOut
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMO_W = ($clog2(MAX_MEASURE_CYCLES) > 18) ? $clog2(MAX_MEASURE_CYCLES) : 18;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_GO     = 3'd2,
        ST_LOAD   = 3'd3,
        ST_RESULT = 3'd4,
        ST_EARLY  = 3'd5
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             cc_q, cc_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timed_out_q, timed_out_d;
    state_t           state_q, state_d;

    logic             press;
    logic             cc_rise;

    // Button path: synchroniser, hold-time debounce, rising-edge pulse
    always_comb begin
        sync1_d    = iGo;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_prev_d = deb_q;
        cc_d       = iCountComplete;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign press   = deb_q & ~deb_prev_q;
    assign cc_rise = iCountComplete & ~cc_q;

    always_comb begin
        state_d     = state_q;
        tmo_cnt_d   = '0;
        timed_out_d = timed_out_q;
        case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (press)        state_d = ST_EARLY;
                else if (cc_rise) state_d = ST_GO;
            end
            ST_GO: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (press) begin
                    state_d = ST_LOAD;
                end else if (tmo_cnt_q == TMO_W'(MAX_MEASURE_CYCLES - 1)) begin
                    state_d     = ST_RESULT;
                    timed_out_d = 1'b1;
                end
            end
            ST_LOAD: begin
                // A press here is dropped rather than carried into RESULT
                state_d     = ST_RESULT;
                timed_out_d = 1'b0;
            end
            ST_RESULT, ST_EARLY: begin
                if (press) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            deb_cnt_q   <= '0;
            cc_q        <= 1'b0;
            tmo_cnt_q   <= '0;
            timed_out_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            deb_cnt_q   <= deb_cnt_d;
            cc_q        <= cc_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timed_out_q <= timed_out_d;
            state_q     <= state_d;
        end
    end

    // Moore decode of the registered state
    always_comb begin
        oStart_down_count = (state_q != ST_WAIT);
        oStart_up_count   = (state_q != ST_GO);
        oLoad_score       = (state_q == ST_LOAD);
        oFalseStart       = (state_q == ST_EARLY);
        oTimedOut         = (state_q == ST_RESULT) & timed_out_q;
        case (state_q)
            ST_WAIT:         oScreen = 2'd1;
            ST_GO, ST_LOAD:  oScreen = 2'd2;
            ST_RESULT:       oScreen = 2'd3;
            default:         oScreen = 2'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_reaction_control.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_reaction_control
// Function : Randomised scenario bench for reaction_control with a
//            behavioural model of the test sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reaction_control;

    localparam int DEB  = 4;
    localparam int MAXM = 100;
    localparam logic [6:0] RST_VEC = 7'b1100000;

    localparam int P_IDLE = 0, P_WAIT = 1, P_GO = 2, P_LOAD = 3, P_RESULT = 4, P_EARLY = 5;

    logic       clk = 1'b0;
    logic       iResetn = 1'b0;
    logic       iGo = 1'b0;
    logic       iCountComplete = 1'b0;
    logic       oStart_down_count, oStart_up_count, oLoad_score, oFalseStart, oTimedOut;
    logic [1:0] oScreen;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    reaction_control #(.DEBOUNCE_CYCLES(DEB), .MAX_MEASURE_CYCLES(MAXM)) dut (
        .clk(clk), .iResetn(iResetn), .iGo(iGo), .iCountComplete(iCountComplete),
        .oStart_down_count(oStart_down_count), .oStart_up_count(oStart_up_count),
        .oLoad_score(oLoad_score), .oScreen(oScreen),
        .oFalseStart(oFalseStart), .oTimedOut(oTimedOut)
    );

    wire [6:0] dut_vec = {oStart_down_count, oStart_up_count, oLoad_score, oScreen, oFalseStart, oTimedOut};

    // Behavioural model: button seen two cycles late, accepted after DEB
    // consecutive differing samples; test phase advanced from the rules.
    logic [1:0] m_sync;
    logic       m_deb, m_deb_prev, m_cc_prev, m_to;
    int         m_run, m_phase, m_go_elapsed;
    wire        m_press = m_deb & ~m_deb_prev;
    wire        m_ccr   = iCountComplete & ~m_cc_prev;

    always @(posedge clk or negedge iResetn) begin
        if (!iResetn) begin
            m_sync <= 2'b00; m_deb <= 1'b0; m_deb_prev <= 1'b0; m_cc_prev <= 1'b0;
            m_to <= 1'b0; m_run <= 0; m_phase <= P_IDLE; m_go_elapsed <= 0;
        end else begin
            m_sync     <= {m_sync[0], iGo};
            m_deb_prev <= m_deb;
            m_cc_prev  <= iCountComplete;
            if (m_sync[1] == m_deb) m_run <= 0;
            else if (m_run + 1 >= DEB) begin m_deb <= m_sync[1]; m_run <= 0; end
            else m_run <= m_run + 1;
            m_go_elapsed <= (m_phase == P_GO) ? m_go_elapsed + 1 : 0;
            case (m_phase)
                P_IDLE: if (m_press) m_phase <= P_WAIT;
                P_WAIT: if (m_press) m_phase <= P_EARLY; else if (m_ccr) m_phase <= P_GO;
                P_GO: begin
                    if (m_press) m_phase <= P_LOAD;
                    else if (m_go_elapsed + 1 == MAXM) begin m_phase <= P_RESULT; m_to <= 1'b1; end
                end
                P_LOAD: begin m_phase <= P_RESULT; m_to <= 1'b0; end
                default: if (m_press) m_phase <= P_IDLE;
            endcase
        end
    end

    function automatic logic [6:0] exp_vec();
        logic [1:0] scr;
        case (m_phase)
            P_WAIT:         scr = 2'd1;
            P_GO, P_LOAD:   scr = 2'd2;
            P_RESULT:       scr = 2'd3;
            default:        scr = 2'd0;
        endcase
        return {m_phase != P_WAIT, m_phase != P_GO, m_phase == P_LOAD, scr,
                m_phase == P_EARLY, (m_phase == P_RESULT) && m_to};
    endfunction

    // Observation record, read back by the scenario tasks
    logic       div_seen = 1'b0, load_last = 1'b0;
    logic [6:0] div_dut, div_exp;
    int         load_pulses = 0, load_hi = 0;

    always @(negedge clk) begin
        if (dut_vec !== exp_vec() && !div_seen) begin
            div_seen = 1'b1; div_dut = dut_vec; div_exp = exp_vec();
        end
        if (oLoad_score === 1'b1) load_hi++;
        if (oLoad_score === 1'b1 && !load_last) load_pulses++;
        load_last = (oLoad_score === 1'b1);
    end

    task automatic clear_obs();
        div_seen = 1'b0; load_pulses = 0; load_hi = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press_button(input int hold);
        iGo = 1'b1; cyc(hold);
        iGo = 1'b0; cyc(DEB + 4);
    endtask

    task automatic pulse_cc(input int n);
        iCountComplete = 1'b1; cyc(n);
        iCountComplete = 1'b0; cyc(2);
    endtask

    task automatic test_reset();
        iResetn = 1'b0; cyc(3);
        n_cmp++; if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL reset_outputs got=%b want=%b", dut_vec, RST_VEC); end
        iResetn = 1'b1; cyc(5);
        n_cmp++; if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL post_reset_idle got=%b want=%b", dut_vec, RST_VEC); end
    endtask

    task automatic test_normal();
        int h;
        h = $urandom_range(8, 12);
        clear_obs();
        press_button(h);
        n_cmp++; if (oScreen !== 2'd1 || oStart_down_count !== 1'b0) begin n_bad++; $display("FAIL normal_wait screen=%0d down=%b want 1/0", oScreen, oStart_down_count); end
        cyc($urandom_range(3, 20));
        pulse_cc(50);
        n_cmp++; if (oScreen !== 2'd2 || oStart_up_count !== 1'b0 || oStart_down_count !== 1'b1) begin n_bad++; $display("FAIL normal_go screen=%0d up=%b down=%b want 2/0/1", oScreen, oStart_up_count, oStart_down_count); end
        cyc(28);
        press_button(h);
        n_cmp++; if (oScreen !== 2'd3 || oTimedOut !== 1'b0) begin n_bad++; $display("FAIL normal_result screen=%0d to=%b want 3/0", oScreen, oTimedOut); end
        n_cmp++; if (load_pulses !== 1 || load_hi !== 1) begin n_bad++; $display("FAIL normal_load_pulse pulses=%0d cycles=%0d want 1/1", load_pulses, load_hi); end
        press_button(h);
        n_cmp++; if (oScreen !== 2'd0) begin n_bad++; $display("FAIL normal_back_idle screen=%0d want 0", oScreen); end
        n_cmp++; if (div_seen !== 1'b0) begin n_bad++; $display("FAIL normal_trace got=%b want=%b", div_dut, div_exp); end
    endtask

    task automatic test_false_start();
        clear_obs();
        press_button($urandom_range(8, 12));
        cyc($urandom_range(1, 10));
        press_button($urandom_range(8, 12));
        n_cmp++; if (oScreen !== 2'd0 || oFalseStart !== 1'b1) begin n_bad++; $display("FAIL early_enter screen=%0d fs=%b want 0/1", oScreen, oFalseStart); end
        pulse_cc(50);
        n_cmp++; if (oScreen !== 2'd0 || oFalseStart !== 1'b1 || load_pulses !== 0) begin n_bad++; $display("FAIL early_cc_ignored screen=%0d fs=%b loads=%0d want 0/1/0", oScreen, oFalseStart, load_pulses); end
        press_button($urandom_range(8, 12));
        n_cmp++; if (oScreen !== 2'd0 || oFalseStart !== 1'b0) begin n_bad++; $display("FAIL early_exit screen=%0d fs=%b want 0/0", oScreen, oFalseStart); end
        n_cmp++; if (div_seen !== 1'b0) begin n_bad++; $display("FAIL early_trace got=%b want=%b", div_dut, div_exp); end
    endtask

    task automatic test_timeout();
        int go_cnt;
        logic seen;
        clear_obs();
        press_button($urandom_range(8, 12));
        cyc($urandom_range(2, 15));
        go_cnt = 0; seen = 1'b0;
        iCountComplete = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (i == 49) iCountComplete = 1'b0;
            if (oScreen === 2'd2) begin go_cnt++; seen = 1'b1; end
            else if (seen) break;
        end
        iCountComplete = 1'b0;
        #1;
        n_cmp++; if (go_cnt !== MAXM) begin n_bad++; $display("FAIL timeout_go_cycles got=%0d want=%0d", go_cnt, MAXM); end
        n_cmp++; if (oScreen !== 2'd3 || oTimedOut !== 1'b1) begin n_bad++; $display("FAIL timeout_result screen=%0d to=%b want 3/1", oScreen, oTimedOut); end
        n_cmp++; if (load_pulses !== 0) begin n_bad++; $display("FAIL timeout_no_load got=%0d want 0", load_pulses); end
        press_button($urandom_range(8, 12));
        n_cmp++; if (oScreen !== 2'd0 || oTimedOut !== 1'b0) begin n_bad++; $display("FAIL timeout_exit screen=%0d to=%b want 0/0", oScreen, oTimedOut); end
        n_cmp++; if (div_seen !== 1'b0) begin n_bad++; $display("FAIL timeout_trace got=%b want=%b", div_dut, div_exp); end
    endtask

    task automatic test_debounce();
        clear_obs();
        for (int k = 0; k < 3; k++) begin
            iGo = 1'b1; cyc($urandom_range(1, DEB - 1));
            iGo = 1'b0; cyc($urandom_range(DEB + 4, DEB + 10));
        end
        n_cmp++; if (oScreen !== 2'd0) begin n_bad++; $display("FAIL glitch_ignored screen=%0d want 0", oScreen); end
        // Press pulse and completion edge land on the same clock edge
        press_button(10);
        iGo = 1'b1; cyc(DEB + 2);
        iCountComplete = 1'b1; cyc(4);
        n_cmp++; if (oScreen !== 2'd0 || oFalseStart !== 1'b1) begin n_bad++; $display("FAIL simultaneous_press_cc screen=%0d fs=%b want 0/1", oScreen, oFalseStart); end
        iCountComplete = 1'b0; cyc(6);
        iGo = 1'b0; cyc(DEB + 4);
        press_button(10);
        n_cmp++; if (oScreen !== 2'd0 || oFalseStart !== 1'b0) begin n_bad++; $display("FAIL simultaneous_exit screen=%0d fs=%b want 0/0", oScreen, oFalseStart); end
        // Button held across WAIT to GO produces only the one press
        iGo = 1'b1; cyc(12);
        n_cmp++; if (oScreen !== 2'd1) begin n_bad++; $display("FAIL held_wait screen=%0d want 1", oScreen); end
        iCountComplete = 1'b1; cyc(3);
        n_cmp++; if (oScreen !== 2'd2) begin n_bad++; $display("FAIL held_go_enter screen=%0d want 2", oScreen); end
        cyc(47);
        iCountComplete = 1'b0;
        iGo = 1'b0; cyc(DEB + 4);
        n_cmp++; if (oScreen !== 2'd2 || load_pulses !== 0) begin n_bad++; $display("FAIL held_no_second_press screen=%0d loads=%0d want 2/0", oScreen, load_pulses); end
        press_button(8);
        n_cmp++; if (oScreen !== 2'd3 || load_pulses !== 1) begin n_bad++; $display("FAIL held_result screen=%0d loads=%0d want 3/1", oScreen, load_pulses); end
        press_button(8);
        n_cmp++; if (div_seen !== 1'b0) begin n_bad++; $display("FAIL debounce_trace got=%b want=%b", div_dut, div_exp); end
    endtask

    task automatic test_async_reset();
        logic got;
        clear_obs();
        // Reset in the middle of GO
        press_button($urandom_range(8, 12));
        iCountComplete = 1'b1; cyc($urandom_range(3, 30));
        n_cmp++; if (oScreen !== 2'd2) begin n_bad++; $display("FAIL arst_go_reached screen=%0d want 2", oScreen); end
        @(posedge clk); #3;
        iResetn = 1'b0; #1;
        n_cmp++; if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL arst_mid_go got=%b want=%b", dut_vec, RST_VEC); end
        iCountComplete = 1'b0; #3;
        iResetn = 1'b1; cyc(2);
        n_cmp++; if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL arst_go_release got=%b want=%b", dut_vec, RST_VEC); end
        // Reset during the single LOAD cycle
        press_button($urandom_range(8, 12));
        pulse_cc(50);
        cyc($urandom_range(1, 10));
        iGo = 1'b1; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (oLoad_score === 1'b1) got = 1'b1;
        end
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL arst_load_reached got=%b want 1", got); end
        #2 iResetn = 1'b0; #1;
        n_cmp++; if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL arst_mid_load got=%b want=%b", dut_vec, RST_VEC); end
        iGo = 1'b0; #6;
        iResetn = 1'b1; cyc(3);
        n_cmp++; if (dut_vec !== RST_VEC) begin n_bad++; $display("FAIL arst_load_release got=%b want=%b", dut_vec, RST_VEC); end
        n_cmp++; if (div_seen !== 1'b0) begin n_bad++; $display("FAIL arst_trace got=%b want=%b", div_dut, div_exp); end
        test_normal();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_normal();
        test_false_start();
        test_timeout();
        test_debounce();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
